// File: rtl/conv11_pkg.sv
// Shared types for the 1x1 conv parameter loader: FSM states, set selects, ROM width.
package conv11_pkg;

  localparam int ROM_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_W,
    FETCH_B,
    FETCH_S,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SEL_W = 2'd0,
    SEL_B = 2'd1,
    SEL_S = 2'd2
  } sel_e;

  // bit0 = weights, bit1 = biases, bit2 = scales
  function automatic logic [2:0] sel_onehot(input sel_e s);
    logic [2:0] v;
    v = 3'b000;
    case (s)
      SEL_W:   v = 3'b001;
      SEL_B:   v = 3'b010;
      SEL_S:   v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/conv11_fetch_seq.sv
// Burst read sequencer: issues count back-to-back ROM reads from base and
// replays each read one cycle later as a buffer write strobe with its index.
module conv11_fetch_seq #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_vld,
  output logic [CNT_W-1:0]  wr_idx,
  output logic              last
);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  idx_q, idx_d;

  assign last   = busy_q && (cnt_q == (count_q - CNT_W'(1)));
  assign rd_en  = busy_q;
  assign addr   = addr_q;
  // An abort also kills the word returning in the same cycle.
  assign wr_vld = vld_q && !abort;
  assign wr_idx = idx_q;

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    addr_d  = addr_q;
    vld_d   = busy_q && !abort;
    idx_d   = cnt_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      count_d = count;
      addr_d  = base;
    end else if (busy_q) begin
      if (abort || last) begin
        busy_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/conv11_param_loader.sv
// Fetches weight/bias/scale sets from the parameter ROM into local buffers and
// publishes a completed set onto flat output buses when the controller asks.
module conv11_param_loader
  import conv11_pkg::*;
#(
  parameter int IN_CH   = 8,
  parameter int OUT_CH  = 8,
  parameter int W_WIDTH = 8,
  parameter int B_WIDTH = 32,
  parameter int S_WIDTH = 16,
  parameter int ADDR_W  = 16,
  parameter int W_BASE  = 0,
  parameter int B_BASE  = 64,
  parameter int S_BASE  = 72
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_weight_en,
  input  logic                              read_weight_en,
  input  logic                              load_bias_en,
  input  logic                              read_bias_en,
  input  logic                              load_scale_en,
  input  logic                              read_scale_en,
  output logic                              weight_load_done,
  output logic                              bias_load_done,
  output logic                              scale_load_done,
  output logic                              mem_rd_en,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic [ROM_DW-1:0]                 mem_rd_data,
  output logic [OUT_CH*IN_CH*W_WIDTH-1:0]   weight_out,
  output logic [OUT_CH*B_WIDTH-1:0]         bias_out,
  output logic [OUT_CH*S_WIDTH-1:0]         scale_out
);

  localparam int NW    = IN_CH * OUT_CH;
  localparam int CNT_W = $clog2(NW + 1);

  state_e state_q, state_d;
  sel_e   sel_q, sel_d;
  logic [2:0] valid_q, valid_d;
  logic [2:0] done_q, done_d;
  logic       start, abort, cur_load;

  logic [ADDR_W-1:0] seq_base;
  logic [CNT_W-1:0]  seq_count;
  logic              seq_wr_vld, seq_last;
  logic [CNT_W-1:0]  seq_wr_idx;

  logic [W_WIDTH-1:0] w_buf_q [NW];
  logic [B_WIDTH-1:0] b_buf_q [OUT_CH];
  logic [S_WIDTH-1:0] s_buf_q [OUT_CH];

  logic [NW*W_WIDTH-1:0]     weight_q;
  logic [OUT_CH*B_WIDTH-1:0] bias_q;
  logic [OUT_CH*S_WIDTH-1:0] scale_q;

  always_comb begin
    case (sel_q)
      SEL_W:   cur_load = load_weight_en;
      SEL_B:   cur_load = load_bias_en;
      default: cur_load = load_scale_en;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    start   = 1'b0;
    abort   = 1'b0;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (load_weight_en) begin
          start = 1'b1; sel_d = SEL_W; state_d = FETCH_W;
        end else if (load_bias_en) begin
          start = 1'b1; sel_d = SEL_B; state_d = FETCH_B;
        end else if (load_scale_en) begin
          start = 1'b1; sel_d = SEL_S; state_d = FETCH_S;
        end
      end
      FETCH_W, FETCH_B, FETCH_S: begin
        if (!cur_load) begin
          abort = 1'b1; state_d = IDLE;
        end else if (seq_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!cur_load) begin
          abort = 1'b1; state_d = IDLE;
        end else begin
          state_d = DONE;
          valid_d = valid_d | sel_onehot(sel_q);
        end
      end
      DONE: begin
        if (!cur_load) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A set being refetched is not publishable until its fetch completes.
    if (start) valid_d = valid_d & ~sel_onehot(sel_d);
    if (abort) valid_d = valid_d & ~sel_onehot(sel_q);
    done_d = (state_d == DONE) ? sel_onehot(sel_d) : 3'b000;
  end

  always_comb begin
    case (sel_d)
      SEL_W: begin
        seq_base  = ADDR_W'(W_BASE);
        seq_count = CNT_W'(NW);
      end
      SEL_B: begin
        seq_base  = ADDR_W'(B_BASE);
        seq_count = CNT_W'(OUT_CH);
      end
      default: begin
        seq_base  = ADDR_W'(S_BASE);
        seq_count = CNT_W'(OUT_CH);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_W;
      valid_q <= 3'b000;
      done_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  conv11_fetch_seq #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .base  (seq_base),
    .count (seq_count),
    .rd_en (mem_rd_en),
    .addr  (mem_addr),
    .wr_vld(seq_wr_vld),
    .wr_idx(seq_wr_idx),
    .last  (seq_last)
  );

  // Only the low bits of each ROM word are kept for the narrower parameter types.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) w_buf_q[i] <= '0;
      for (int i = 0; i < OUT_CH; i++) begin
        b_buf_q[i] <= '0;
        s_buf_q[i] <= '0;
      end
    end else if (seq_wr_vld) begin
      for (int i = 0; i < NW; i++) begin
        if (sel_q == SEL_W && seq_wr_idx == CNT_W'(i)) w_buf_q[i] <= mem_rd_data[W_WIDTH-1:0];
      end
      for (int i = 0; i < OUT_CH; i++) begin
        if (sel_q == SEL_B && seq_wr_idx == CNT_W'(i)) b_buf_q[i] <= mem_rd_data[B_WIDTH-1:0];
        if (sel_q == SEL_S && seq_wr_idx == CNT_W'(i)) s_buf_q[i] <= mem_rd_data[S_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
      bias_q   <= '0;
      scale_q  <= '0;
    end else begin
      if (read_weight_en && valid_q[0]) begin
        for (int i = 0; i < NW; i++) weight_q[i*W_WIDTH +: W_WIDTH] <= w_buf_q[i];
      end
      if (read_bias_en && valid_q[1]) begin
        for (int i = 0; i < OUT_CH; i++) bias_q[i*B_WIDTH +: B_WIDTH] <= b_buf_q[i];
      end
      if (read_scale_en && valid_q[2]) begin
        for (int i = 0; i < OUT_CH; i++) scale_q[i*S_WIDTH +: S_WIDTH] <= s_buf_q[i];
      end
    end
  end

  assign weight_load_done = done_q[0];
  assign bias_load_done   = done_q[1];
  assign scale_load_done  = done_q[2];
  assign weight_out       = weight_q;
  assign bias_out         = bias_q;
  assign scale_out        = scale_q;

endmodule

// File: tb/tb_conv11_param_loader.sv
// Bench for conv11_param_loader: ROM model plus a set-level reference of the published buses.
module tb_conv11_param_loader;

  localparam int IN_CH = 8, OUT_CH = 8, W_WIDTH = 8, B_WIDTH = 32, S_WIDTH = 16, ADDR_W = 16;
  localparam int W_BASE = 0, B_BASE = 64, S_BASE = 72;
  localparam int NW = IN_CH * OUT_CH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_weight_en = 0, read_weight_en = 0, load_bias_en = 0, read_bias_en = 0;
  logic load_scale_en = 0, read_scale_en = 0;
  logic weight_load_done, bias_load_done, scale_load_done, mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic [NW*W_WIDTH-1:0] weight_out;
  logic [OUT_CH*B_WIDTH-1:0] bias_out;
  logic [OUT_CH*S_WIDTH-1:0] scale_out;

  logic [31:0] rom [256];
  logic [W_WIDTH-1:0] exp_w [NW];
  logic [B_WIDTH-1:0] exp_b [OUT_CH];
  logic [S_WIDTH-1:0] exp_s [OUT_CH];

  int vectors = 0;
  int miscompares = 0;
  int rd_count = 0;

  conv11_param_loader dut (
    .clk(clk), .rst_n(rst_n),
    .load_weight_en(load_weight_en), .read_weight_en(read_weight_en),
    .load_bias_en(load_bias_en), .read_bias_en(read_bias_en),
    .load_scale_en(load_scale_en), .read_scale_en(read_scale_en),
    .weight_load_done(weight_load_done), .bias_load_done(bias_load_done),
    .scale_load_done(scale_load_done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .weight_out(weight_out), .bias_out(bias_out), .scale_out(scale_out)
  );

  always #5 clk = ~clk;

  // ROM returns data one cycle after the read strobe; garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= rom[mem_addr[7:0]];
    else           mem_rd_data <= $urandom;
  end

  always @(negedge clk) if (rst_n && mem_rd_en) rd_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int n_of(input int sel);
    return (sel == 0) ? NW : OUT_CH;
  endfunction

  function automatic int base_of(input int sel);
    return (sel == 0) ? W_BASE : (sel == 1) ? B_BASE : S_BASE;
  endfunction

  task automatic set_load(input int sel, input logic v);
    case (sel)
      0: load_weight_en = v;
      1: load_bias_en = v;
      default: load_scale_en = v;
    endcase
  endtask

  task automatic set_read(input int sel, input logic v);
    case (sel)
      0: read_weight_en = v;
      1: read_bias_en = v;
      default: read_scale_en = v;
    endcase
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? weight_load_done : (sel == 1) ? bias_load_done : scale_load_done;
  endfunction

  // Reference: a published set equals the low bits of its ROM region.
  task automatic publish(input int sel);
    for (int k = 0; k < n_of(sel); k++) begin
      if (sel == 0)      exp_w[k] = rom[W_BASE + k][W_WIDTH-1:0];
      else if (sel == 1) exp_b[k] = rom[B_BASE + k][B_WIDTH-1:0];
      else               exp_s[k] = rom[S_BASE + k][S_WIDTH-1:0];
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NW; k++) exp_w[k] = '0;
    for (int k = 0; k < OUT_CH; k++) begin exp_b[k] = '0; exp_s[k] = '0; end
  endtask

  function automatic logic [NW*W_WIDTH-1:0] exp_weight_bus();
    logic [NW*W_WIDTH-1:0] v;
    for (int k = 0; k < NW; k++) v[k*W_WIDTH +: W_WIDTH] = exp_w[k];
    return v;
  endfunction

  function automatic logic [OUT_CH*B_WIDTH-1:0] exp_bias_bus();
    logic [OUT_CH*B_WIDTH-1:0] v;
    for (int k = 0; k < OUT_CH; k++) v[k*B_WIDTH +: B_WIDTH] = exp_b[k];
    return v;
  endfunction

  function automatic logic [OUT_CH*S_WIDTH-1:0] exp_scale_bus();
    logic [OUT_CH*S_WIDTH-1:0] v;
    for (int k = 0; k < OUT_CH; k++) v[k*S_WIDTH +: S_WIDTH] = exp_s[k];
    return v;
  endfunction

  // Full handshake for one set: fetch, check addresses and latency, publish, release.
  task automatic fetch_and_read(input int sel, input string tag);
    int n, base, nreads, cyc;
    bit got;
    n = n_of(sel); base = base_of(sel); nreads = 0; cyc = 0; got = 0;
    set_load(sel, 1'b1);
    for (int t = 1; t <= n + 10 && !got; t++) begin
      tick();
      if (mem_rd_en) begin
        vectors++;
        if (mem_addr !== ADDR_W'(base + nreads)) begin
          miscompares++;
          $display("FAIL %s_addr read %0d: got %0d want %0d", tag, nreads, mem_addr, base + nreads);
        end
        nreads++;
      end
      if (get_done(sel) === 1'b1) begin got = 1; cyc = t; end
    end
    vectors++;
    if (cyc != n + 2) begin
      miscompares++;
      $display("FAIL %s_done_latency: got %0d want %0d", tag, cyc, n + 2);
    end
    vectors++;
    if (nreads != n) begin
      miscompares++;
      $display("FAIL %s_read_count: got %0d want %0d", tag, nreads, n);
    end
    set_read(sel, 1'b1);
    tick();
    set_read(sel, 1'b0);
    set_load(sel, 1'b0);
    publish(sel);
    vectors++;
    if (get_done(sel) !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done_hold: got %b want 1", tag, get_done(sel));
    end
    tick();
    vectors++;
    if (get_done(sel) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_clear: got %b want 0", tag, get_done(sel));
    end
    vectors++;
    if (weight_out !== exp_weight_bus() || bias_out !== exp_bias_bus() || scale_out !== exp_scale_bus()) begin
      miscompares++;
      $display("FAIL %s_outputs: bias got %h want %h scale got %h want %h", tag,
               bias_out, exp_bias_bus(), scale_out, exp_scale_bus());
    end
    $display("fetch %s: done after %0d cycles, %0d reads", tag, cyc, nreads);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({weight_load_done, bias_load_done, scale_load_done, mem_rd_en} !== 4'b0 || mem_addr !== '0 ||
        weight_out !== '0 || bias_out !== '0 || scale_out !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rd_en %b addr %0d dones %b%b%b", mem_rd_en, mem_addr,
               weight_load_done, bias_load_done, scale_load_done);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (mem_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_rd_en: got %b want 0", mem_rd_en);
    end
    $display("reset: initial state checked");
  endtask

  task automatic test_weights();
    for (int i = 0; i < NW; i++) rom[W_BASE + i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
    fetch_and_read(0, "weights");
    for (int k = 0; k < NW; k++) begin
      vectors++;
      if (weight_out[k*W_WIDTH +: W_WIDTH] !== W_WIDTH'(k)) begin
        miscompares++;
        $display("FAIL weight_slice %0d: got %0d want %0d", k, weight_out[k*W_WIDTH +: W_WIDTH], k);
      end
    end
    vectors++;
    if (mem_rd_en !== 1'b0 || mem_addr !== ADDR_W'(W_BASE + NW - 1)) begin
      miscompares++;
      $display("FAIL addr_hold: rd_en %b addr %0d want 0/%0d", mem_rd_en, mem_addr, W_BASE + NW - 1);
    end
  endtask

  task automatic test_bias_scale();
    for (int j = 0; j < OUT_CH; j++) begin
      rom[B_BASE + j] = 32'hFFFF_FF00 + 32'(j);
      rom[S_BASE + j] = ($urandom & 32'hFFFF_0000) | (32'h1234 + 32'(j));
    end
    fetch_and_read(1, "bias");
    fetch_and_read(2, "scale");
    for (int j = 0; j < OUT_CH; j++) begin
      vectors++;
      if (bias_out[j*B_WIDTH +: B_WIDTH] !== 32'hFFFF_FF00 + 32'(j) ||
          scale_out[j*S_WIDTH +: S_WIDTH] !== 16'h1234 + 16'(j)) begin
        miscompares++;
        $display("FAIL bias_scale_slice %0d: got %h/%h want %h/%h", j, bias_out[j*B_WIDTH +: B_WIDTH],
                 scale_out[j*S_WIDTH +: S_WIDTH], 32'hFFFF_FF00 + 32'(j), 16'h1234 + 16'(j));
      end
    end
  endtask

  task automatic test_abort();
    bit seen, done_seen;
    seen = 0; done_seen = 0;
    for (int j = 0; j < OUT_CH; j++) rom[B_BASE + j] = $urandom;
    load_bias_en = 1'b1;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      if (mem_rd_en && mem_addr == ADDR_W'(B_BASE + 3)) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL abort_reach_cnt3: got no read at %0d want one", B_BASE + 3);
    end
    load_bias_en = 1'b0;
    tick();
    vectors++;
    if (mem_rd_en !== 1'b0 || mem_addr !== ADDR_W'(B_BASE + 3) || bias_load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_stop: rd_en %b addr %0d done %b want 0/%0d/0", mem_rd_en, mem_addr,
               bias_load_done, B_BASE + 3);
    end
    repeat (12) begin
      tick();
      if (bias_load_done === 1'b1 || mem_rd_en === 1'b1) done_seen = 1;
    end
    vectors++;
    if (done_seen) begin
      miscompares++;
      $display("FAIL abort_quiet: got activity after abort want none");
    end
    read_bias_en = 1'b1;
    tick();
    read_bias_en = 1'b0;
    tick();
    vectors++;
    if (bias_out !== exp_bias_bus()) begin
      miscompares++;
      $display("FAIL abort_bias_unchanged: got %h want %h", bias_out, exp_bias_bus());
    end
    $display("abort: bias fetch dropped at cnt 3");
    fetch_and_read(1, "bias_refetch");
  endtask

  task automatic test_priority();
    for (int i = 0; i < 80; i++) rom[i] = $urandom;
    load_scale_en = 1'b1;
    fetch_and_read(0, "prio_weights");
    vectors++;
    if (scale_load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_no_scale_done: got %b want 0", scale_load_done);
    end
    fetch_and_read(2, "prio_scale");
  endtask

  task automatic test_back_to_back();
    int r0;
    for (int i = 0; i < 80; i++) rom[i] = $urandom;
    r0 = rd_count;
    fetch_and_read(0, "b2b_weights");
    fetch_and_read(1, "b2b_bias");
    fetch_and_read(2, "b2b_scale");
    vectors++;
    if (rd_count - r0 != 80) begin
      miscompares++;
      $display("FAIL b2b_rd_count: got %0d want 80", rd_count - r0);
    end
    $display("back_to_back: %0d reads", rd_count - r0);
  endtask

  task automatic test_reset_midfetch();
    bit seen;
    seen = 0;
    for (int i = 0; i < 80; i++) rom[i] = $urandom;
    load_weight_en = 1'b1;
    for (int t = 0; t < 40 && !seen; t++) begin
      tick();
      if (mem_rd_en && mem_addr == ADDR_W'(W_BASE + 20)) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL midreset_reach_cnt20: got no read at 20 want one");
    end
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    vectors++;
    if ({weight_load_done, bias_load_done, scale_load_done, mem_rd_en} !== 4'b0 || mem_addr !== '0 ||
        weight_out !== '0 || bias_out !== '0 || scale_out !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: rd_en %b addr %0d bias %h", mem_rd_en, mem_addr, bias_out);
    end
    load_weight_en = 1'b0;
    tick();
    rst_n = 1'b1;
    read_weight_en = 1'b1;
    tick();
    read_weight_en = 1'b0;
    tick();
    vectors++;
    if (mem_rd_en !== 1'b0 || weight_load_done !== 1'b0 || weight_out !== exp_weight_bus()) begin
      miscompares++;
      $display("FAIL midreset_release: rd_en %b done %b weight_out nonzero %b want 0/0/0",
               mem_rd_en, weight_load_done, weight_out != '0);
    end
    $display("reset: asserted mid weight fetch at cnt 20");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    clear_model();
    test_reset();
    test_weights();
    test_bias_scale();
    test_abort();
    test_priority();
    test_back_to_back();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
